// File: rtl/mem_stage_wreg_if.sv
// mem_stage_wreg_if: bundle between the pipeline and the memory stage.
//   M_*       : M pipeline register contents (driven by the pipeline)
//   W_stall/W_bubble : pipeline control for the W register
//   m_valM/m_stat    : combinational memory-stage results (to decode forwarding)
//   W_*       : W pipeline register contents
// master = pipeline side, slave = memory stage.
interface mem_stage_wreg_if;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    modport master (
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
               W_stall, W_bubble,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    modport slave (
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
               W_stall, W_bubble,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/mem_stage_wreg.sv
// mem_stage_wreg: Y86-64 memory stage plus W pipeline register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_stage_wreg_if.slave (M bundle in, m_valM/m_stat and W register out)
// Data memory is byte addressed, 64-bit little-endian words, MEM_BYTES bytes.
// Reads are combinational; writes land on the rising edge. Memory is not reset.
module mem_stage_wreg #(
    parameter int MEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_stage_wreg_if.slave  bus
);
    localparam int          AW       = $clog2(MEM_BYTES);
    localparam logic [63:0] LAST_ADR = 64'(MEM_BYTES - 8);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    logic [7:0]    mem [MEM_BYTES];

    logic          mem_rd;
    logic          mem_wr;
    logic [63:0]   mem_addr;
    logic          dmem_error;
    logic [AW-1:0] base;
    logic [63:0]   rdata;
    logic          wr_en;

    always_comb begin
        mem_rd   = (bus.M_icode == I_MRMOVQ) || (bus.M_icode == I_POPQ) ||
                   (bus.M_icode == I_RET);
        mem_wr   = (bus.M_icode == I_RMMOVQ) || (bus.M_icode == I_PUSHQ) ||
                   (bus.M_icode == I_CALL);
        // Stack pops take the old %rsp carried in valA; everything else uses valE.
        mem_addr = ((bus.M_icode == I_POPQ) || (bus.M_icode == I_RET)) ?
                   bus.M_valA : bus.M_valE;
        // Full 64-bit compare so huge addresses cannot alias into the array.
        dmem_error = (mem_rd || mem_wr) && (mem_addr > LAST_ADR);
        base       = mem_addr[AW-1:0];
    end

    // One read lane per byte of the word; lane k holds mem[addr+k].
    for (genvar k = 0; k < 8; k++) begin : g_rd_lane
        assign rdata[8*k +: 8] = mem[base + AW'(k)];
    end

    assign bus.m_valM = (mem_rd && !dmem_error) ? rdata : 64'd0;
    assign bus.m_stat = dmem_error ? S_ADR : bus.M_stat;

    // A store retires only if neither this instruction nor the one ahead in W
    // has faulted, so nothing past an exception modifies memory.
    assign wr_en = rst_n && mem_wr && !dmem_error &&
                   (bus.M_stat == S_AOK) && (bus.W_stat == S_AOK);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++)
                mem[base + AW'(k)] <= bus.M_valA[8*k +: 8];
        end
    end

    // W register: reset/bubble load a NOP; stall beats bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || (!bus.W_stall && bus.W_bubble)) begin
            bus.W_stat  <= S_AOK;
            bus.W_icode <= I_NOP;
            bus.W_valE  <= '0;
            bus.W_valM  <= '0;
            bus.W_dstE  <= R_NONE;
            bus.W_dstM  <= R_NONE;
        end else if (!bus.W_stall) begin
            bus.W_stat  <= bus.m_stat;
            bus.W_icode <= bus.M_icode;
            bus.W_valE  <= bus.M_valE;
            bus.W_valM  <= bus.m_valM;
            bus.W_dstE  <= bus.M_dstE;
            bus.W_dstM  <= bus.M_dstM;
        end
    end
endmodule

// File: tb/tb_mem_stage_wreg.sv
module tb_mem_stage_wreg;
    localparam int MEM = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_wreg_if bus ();

    mem_stage_wreg #(.MEM_BYTES(MEM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte array plus the architectural W register.
    logic [7:0]  mm [MEM];
    logic [2:0]  w_stat;
    logic [3:0]  w_icode, w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;
    logic [63:0] last_valM;
    logic [2:0]  last_stat;

    function automatic logic [63:0] mread(input logic [63:0] a);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = mm[int'(a) + k];
        return v;
    endfunction

    task automatic step(input logic rst, input logic [2:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic stall, input logic bub);
        logic rd, wr, err;
        logic [63:0] a, ev;
        logic [2:0] es;
        @(negedge clk);
        rst_n = rst; bus.M_stat = st; bus.M_icode = ic; bus.M_Cnd = ve[0];
        bus.M_valE = ve; bus.M_valA = va; bus.M_dstE = de; bus.M_dstM = dm;
        bus.W_stall = stall; bus.W_bubble = bub;
        rd  = ic inside {4'h5, 4'hB, 4'h9};
        wr  = ic inside {4'h4, 4'hA, 4'h8};
        a   = (ic inside {4'hB, 4'h9}) ? va : ve;
        err = (rd || wr) && (a > 64'(MEM - 8));
        ev  = (rd && !err) ? mread(a) : 64'd0;
        es  = err ? 3'd3 : st;
        #1;
        last_valM = bus.m_valM; last_stat = bus.m_stat;
        chk("m_valM", bus.m_valM, ev);
        chk("m_stat", {61'd0, bus.m_stat}, {61'd0, es});
        @(posedge clk);
        if (rst && wr && !err && st == 3'd1 && w_stat == 3'd1)
            for (int k = 0; k < 8; k++) mm[int'(a) + k] = va[8*k +: 8];
        if (!rst || (!stall && bub)) begin
            w_stat = 3'd1; w_icode = 4'h1; w_valE = 0; w_valM = 0; w_dstE = 4'hF; w_dstM = 4'hF;
        end else if (!stall) begin
            w_stat = es; w_icode = ic; w_valE = ve; w_valM = ev; w_dstE = de; w_dstM = dm;
        end
        #1;
        chk("W_stat",  {61'd0, bus.W_stat},  {61'd0, w_stat});
        chk("W_icode", {60'd0, bus.W_icode}, {60'd0, w_icode});
        chk("W_valE",  bus.W_valE, w_valE);
        chk("W_valM",  bus.W_valM, w_valM);
        chk("W_dstE",  {60'd0, bus.W_dstE},  {60'd0, w_dstE});
        chk("W_dstM",  {60'd0, bus.W_dstM},  {60'd0, w_dstM});
    endtask

    // Shorthand for an AOK instruction with no control asserted.
    task automatic op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                      input logic [3:0] dm);
        step(1'b1, 3'd1, ic, ve, va, 4'h2, dm, 1'b0, 1'b0);
    endtask

    logic [63:0] top_word, rv, ra, rb;
    logic [3:0]  hold_ic;

    initial begin
        rst_n = 1'b0;
        bus.M_stat = 3'd1; bus.M_icode = 4'h1; bus.M_Cnd = 1'b0; bus.M_valE = '0;
        bus.M_valA = '0; bus.M_dstE = 4'hF; bus.M_dstM = 4'hF;
        bus.W_stall = 1'b0; bus.W_bubble = 1'b0;
        w_stat = 3'd1; w_icode = 4'h1; w_valE = 0; w_valM = 0; w_dstE = 4'hF; w_dstM = 4'hF;

        // Reset with an arbitrary write in M: W bubbles, memory untouched.
        step(1'b0, 3'd1, 4'h4, 64'h40, 64'hDEAD, 4'h3, 4'h5, 1'b0, 1'b0);
        chk("rst_W_icode", {60'd0, bus.W_icode}, 64'd1);
        chk("rst_W_dstE",  {60'd0, bus.W_dstE},  64'hF);

        // Fill memory so every later read has a known expected value.
        for (int a = 0; a <= MEM - 8; a += 8)
            op(4'h4, 64'(a), {$urandom, $urandom}, 4'hF);

        // Store / load.
        op(4'h4, 64'h40, 64'h1122334455667788, 4'hF);
        op(4'h5, 64'h40, 64'h0, 4'h3);
        chk("ld_valM", last_valM, 64'h1122334455667788);
        chk("ld_W_valM", bus.W_valM, 64'h1122334455667788);
        chk("ld_W_dstM", {60'd0, bus.W_dstM}, 64'd3);

        // Bounds.
        op(4'h5, 64'h3F8, 64'h0, 4'h4);
        chk("bnd_ok_stat", {61'd0, last_stat}, 64'd1);
        top_word = last_valM;
        op(4'h5, 64'h3F9, 64'h0, 4'h4);
        chk("bnd_err_stat", {61'd0, last_stat}, 64'd3);
        chk("bnd_err_valM", last_valM, 64'd0);
        op(4'h4, 64'h3FC, 64'hAAAA_BBBB_CCCC_DDDD, 4'hF);
        chk("bnd_wr_Wstat", {61'd0, bus.W_stat}, 64'd3);
        op(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'h4);
        chk("bnd_wrap_stat", {61'd0, last_stat}, 64'd3);
        op(4'h5, 64'h3F8, 64'h0, 4'h4);
        chk("bnd_unchanged", last_valM, top_word);

        // Address select.
        op(4'h4, 64'h100, 64'h0101_0101_0101_0101, 4'hF);
        op(4'h4, 64'h108, 64'h0202_0202_0202_0202, 4'hF);
        op(4'hB, 64'h108, 64'h100, 4'h6);
        chk("popq_addr", last_valM, 64'h0101_0101_0101_0101);
        op(4'hA, 64'hF8, 64'h100, 4'hF);
        op(4'h5, 64'hF8, 64'h0, 4'h6);
        chk("pushq_addr", last_valM, 64'h0000_0000_0000_0100);

        // Stall / bubble.
        op(4'h6, 64'h1234, 64'h0, 4'hF);
        hold_ic = bus.W_icode;
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd1, 4'h2, 64'(i), 64'h0, 4'h7, 4'hF, 1'b1, 1'b0);
        chk("stall_icode", {60'd0, bus.W_icode}, 64'h6);
        chk("stall_valE", bus.W_valE, 64'h1234);
        step(1'b1, 3'd1, 4'h2, 64'h55, 64'h0, 4'h7, 4'hF, 1'b0, 1'b1);
        chk("bub_icode", {60'd0, bus.W_icode}, 64'd1);
        chk("bub_dstE", {60'd0, bus.W_dstE}, 64'hF);
        op(4'h6, 64'h77, 64'h0, 4'hF);
        step(1'b1, 3'd1, 4'h2, 64'h99, 64'h0, 4'h7, 4'hF, 1'b1, 1'b1);
        chk("both_hold", bus.W_valE, 64'h77);

        // Exception gating: HLT parked in W blocks a following store.
        op(4'h4, 64'h80, 64'hCAFE_F00D_1234_5678, 4'hF);
        step(1'b1, 3'd2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        step(1'b1, 3'd1, 4'h4, 64'h80, 64'h1, 4'hF, 4'hF, 1'b1, 1'b0);
        step(1'b1, 3'd1, 4'h5, 64'h80, 64'h0, 4'hF, 4'h3, 1'b1, 1'b0);
        chk("exc_gate", last_valM, 64'hCAFE_F00D_1234_5678);
        chk("exc_Wstat", {61'd0, bus.W_stat}, 64'd2);
        step(1'b1, 3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ic;
            logic [2:0] st;
            ic = 4'($urandom_range(0, 11));
            st = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            case ($urandom_range(0, 3))
                0: ra = 64'($urandom_range(0, MEM - 8));
                1: ra = 64'($urandom_range(MEM - 16, MEM + 8));
                2: ra = 64'($urandom_range(0, MEM / 8 - 1)) * 8;
                default: ra = {$urandom, $urandom};
            endcase
            rb = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, MEM - 8)) : {$urandom, $urandom};
            rv = {$urandom, $urandom};
            if (ic inside {4'h9, 4'hB}) rv = ra;
            else rv = rb;
            step(($urandom_range(0, 40) != 0), st, ic, (ic inside {4'h9, 4'hB}) ? rb : ra, rv,
                 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
